// File: rtl/pmp_region_encoder.sv
// pmp_region_encoder - turns a {base, log2 size, perms, lock} request into one NA4/NAPOT PMP entry,
// writes it to the CSR file and reads it back to catch WARL/granularity clamping.
module pmp_region_encoder #(
  parameter int PA_BITS     = 56,
  parameter int PMP_ENTRIES = 16,
  localparam int EW         = $clog2(PMP_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ReqValid,
  output logic                   ReqReady,
  input  logic [EW-1:0]          ReqEntry,
  input  logic [PA_BITS-1:0]     ReqBase,
  input  logic [5:0]             ReqLog2Size,
  input  logic [2:0]             ReqPerm,
  input  logic                   ReqLock,
  input  logic [PMP_ENTRIES-1:0] PMPLocked,
  input  logic [PMP_ENTRIES-1:0] PMPIsTOR,
  output logic                   PMPWrEn,
  output logic [EW-1:0]          PMPWrEntry,
  output logic [PA_BITS-3:0]     PMPWrAdr,
  output logic [7:0]             PMPWrCfg,
  input  logic [PA_BITS-3:0]     PMPRdAdr,
  input  logic [7:0]             PMPRdCfg,
  output logic                   RspValid,
  input  logic                   RspReady,
  output logic [1:0]             RspError
);

  typedef enum logic [2:0] {
    IDLE, CHECK, WRITE, READBACK, RESP
  } state_t;

  state_t state_q, state_d;

  logic [EW-1:0]      entry_q;
  logic [PA_BITS-1:0] base_q;
  logic [5:0]         k_q;
  logic [2:0]         perm_q;
  logic               lock_q;
  logic [1:0]         err_q, err_d;
  logic [EW-1:0]      wr_entry_q;
  logic [PA_BITS-3:0] wr_adr_q, wr_adr_d;
  logic [7:0]         wr_cfg_q, wr_cfg_d;

  logic [PA_BITS-1:0] low_mask;
  logic [PA_BITS-3:0] napot_mask;
  logic               size_err, lock_err, next_tor_lock;
  logic [EW-1:0]      entry_nxt;
  logic [1:0]         a_field;

  // Region decode from the latched request; only consumed while in CHECK.
  always_comb begin
    low_mask   = '0;
    napot_mask = '0;
    for (int i = 0; i < PA_BITS; i++) begin
      low_mask[i] = (i < int'(k_q));
    end
    for (int i = 0; i < PA_BITS - 2; i++) begin
      napot_mask[i] = ((i + 3) < int'(k_q));
    end
    size_err = (int'(k_q) < 2) || (int'(k_q) > PA_BITS) || (|(base_q & low_mask));

    entry_nxt     = entry_q + EW'(1);
    next_tor_lock = (int'(entry_q) < PMP_ENTRIES - 1) && PMPLocked[entry_nxt] && PMPIsTOR[entry_nxt];
    lock_err      = PMPLocked[entry_q] || next_tor_lock;

    a_field  = (k_q == 6'd2) ? 2'b10 : 2'b11;
    wr_adr_d = (k_q == 6'd2) ? base_q[PA_BITS-1:2] : (base_q[PA_BITS-1:2] | napot_mask);
    wr_cfg_d = {lock_q, 2'b00, a_field, perm_q};

    err_d = size_err ? 2'b01 : (lock_err ? 2'b10 : 2'b00);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (ReqValid) state_d = CHECK;
      CHECK:    state_d = (err_d != 2'b00) ? RESP : WRITE;
      WRITE:    state_d = READBACK;
      READBACK: state_d = RESP;
      RESP:     if (RspReady) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      entry_q    <= '0;
      base_q     <= '0;
      k_q        <= '0;
      perm_q     <= '0;
      lock_q     <= 1'b0;
      err_q      <= 2'b00;
      wr_entry_q <= '0;
      wr_adr_q   <= '0;
      wr_cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (ReqValid) begin
          entry_q <= ReqEntry;
          base_q  <= ReqBase;
          k_q     <= ReqLog2Size;
          perm_q  <= ReqPerm;
          lock_q  <= ReqLock;
          err_q   <= 2'b00;
        end
        CHECK: begin
          err_q      <= err_d;
          wr_entry_q <= entry_q;
          wr_adr_q   <= wr_adr_d;
          wr_cfg_q   <= wr_cfg_d;
        end
        // The CSR file answers combinationally for the entry still on PMPWrEntry.
        READBACK: if ((PMPRdAdr != wr_adr_q) || (PMPRdCfg != wr_cfg_q)) err_q <= 2'b11;
        default: ;
      endcase
    end
  end

  assign ReqReady   = (state_q == IDLE) && !reset;
  assign PMPWrEn    = (state_q == WRITE);
  assign RspValid   = (state_q == RESP);
  assign RspError   = err_q;
  assign PMPWrEntry = wr_entry_q;
  assign PMPWrAdr   = wr_adr_q;
  assign PMPWrCfg   = wr_cfg_q;

endmodule

// File: tb/tb_pmp_region_encoder.sv
// tb/tb_pmp_region_encoder.sv - directed bench for pmp_region_encoder with a small PMP CSR file model.
module tb_pmp_region_encoder;

  localparam int PA_BITS = 56;
  localparam int NE      = 16;
  localparam int EW      = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 ReqValid = 1'b0;
  logic                 ReqReady;
  logic [EW-1:0]        ReqEntry = '0;
  logic [PA_BITS-1:0]   ReqBase = '0;
  logic [5:0]           ReqLog2Size = '0;
  logic [2:0]           ReqPerm = '0;
  logic                 ReqLock = 1'b0;
  logic [NE-1:0]        PMPLocked = '0;
  logic [NE-1:0]        PMPIsTOR = '0;
  logic                 PMPWrEn;
  logic [EW-1:0]        PMPWrEntry;
  logic [PA_BITS-3:0]   PMPWrAdr;
  logic [7:0]           PMPWrCfg;
  logic [PA_BITS-3:0]   PMPRdAdr;
  logic [7:0]           PMPRdCfg;
  logic                 RspValid;
  logic                 RspReady = 1'b0;
  logic [1:0]           RspError;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  bit clamp_en = 1'b0;

  logic [PA_BITS-3:0] mem_adr [NE];
  logic [7:0]         mem_cfg [NE];

  always #5 clk = ~clk;

  pmp_region_encoder #(.PA_BITS(PA_BITS), .PMP_ENTRIES(NE)) dut (
    .clk(clk), .reset(reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqEntry(ReqEntry), .ReqBase(ReqBase),
    .ReqLog2Size(ReqLog2Size), .ReqPerm(ReqPerm), .ReqLock(ReqLock),
    .PMPLocked(PMPLocked), .PMPIsTOR(PMPIsTOR),
    .PMPWrEn(PMPWrEn), .PMPWrEntry(PMPWrEntry), .PMPWrAdr(PMPWrAdr), .PMPWrCfg(PMPWrCfg),
    .PMPRdAdr(PMPRdAdr), .PMPRdCfg(PMPRdCfg),
    .RspValid(RspValid), .RspReady(RspReady), .RspError(RspError)
  );

  // CSR file model; clamp_en emulates G=2 granularity by zeroing the low two pmpaddr bits.
  always @(posedge clk) begin
    if (PMPWrEn === 1'b1) begin
      wr_count <= wr_count + 1;
      mem_adr[PMPWrEntry] <= clamp_en ? (PMPWrAdr & ~54'h3) : PMPWrAdr;
      mem_cfg[PMPWrEntry] <= PMPWrCfg;
    end
  end
  assign PMPRdAdr = mem_adr[PMPWrEntry];
  assign PMPRdCfg = mem_cfg[PMPWrEntry];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for the response, acknowledge it.
  // lat counts falling edges after the accept edge until RspValid is seen.
  task automatic run(input logic [EW-1:0] e, input logic [PA_BITS-1:0] b, input logic [5:0] k,
                     input logic [2:0] p, input logic l,
                     output int lat, output logic [1:0] err, output int nwr);
    int w0;
    @(negedge clk);
    chk("req_ready_idle", ReqReady, 1'b1);
    ReqValid = 1'b1; ReqEntry = e; ReqBase = b; ReqLog2Size = k; ReqPerm = p; ReqLock = l;
    w0 = wr_count;
    @(negedge clk);
    ReqValid = 1'b0;
    chk("req_ready_busy", ReqReady, 1'b0);
    lat = 1;
    while (RspValid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (RspValid !== 1'b1) begin
      errors++;
      $error("FAIL rsp_timeout: RspValid not seen within %0d cycles", lat);
    end
    err = RspError;
    nwr = wr_count - w0;
    RspReady = 1'b1;
    @(negedge clk);
    RspReady = 1'b0;
  endtask

  initial begin
    int lat;
    int nwr;
    logic [1:0] err;

    for (int i = 0; i < NE; i++) begin
      mem_adr[i] = '0;
      mem_cfg[i] = '0;
    end

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", ReqReady, 1'b1);
    chk("rst_wren", PMPWrEn, 1'b0);
    chk("rst_rspvalid", RspValid, 1'b0);
    chk("rst_rsperror", RspError, 2'b00);
    chk("rst_wrentry", PMPWrEntry, 4'h0);
    chk("rst_wradr", PMPWrAdr, 54'h0);
    chk("rst_wrcfg", PMPWrCfg, 8'h00);

    // NAPOT 4 KiB region
    run(4'd3, 56'h8000_0000, 6'd12, 3'b011, 1'b0, lat, err, nwr);
    chk("t1_lat", lat, 4);
    chk("t1_err", err, 2'b00);
    chk("t1_nwr", nwr, 1);
    chk("t1_entry", PMPWrEntry, 4'd3);
    chk("t1_adr", PMPWrAdr, 54'h2000_01FF);
    chk("t1_cfg", PMPWrCfg, 8'h1B);
    chk("t1_mem_adr", mem_adr[3], 54'h2000_01FF);
    chk("t1_mem_cfg", mem_cfg[3], 8'h1B);

    // NA4 with lock
    run(4'd0, 56'h1000_0004, 6'd2, 3'b100, 1'b1, lat, err, nwr);
    chk("t2_lat", lat, 4);
    chk("t2_err", err, 2'b00);
    chk("t2_nwr", nwr, 1);
    chk("t2_adr", PMPWrAdr, 54'h0400_0001);
    chk("t2_cfg", PMPWrCfg, 8'h94);

    // Smallest NAPOT (k=3): no trailing ones
    run(4'd7, 56'h0000_0008, 6'd3, 3'b001, 1'b0, lat, err, nwr);
    chk("k3_err", err, 2'b00);
    chk("k3_adr", PMPWrAdr, 54'h2);
    chk("k3_cfg", PMPWrCfg, 8'h19);

    // Whole address space
    run(4'd9, 56'h0, 6'd56, 3'b111, 1'b0, lat, err, nwr);
    chk("kmax_err", err, 2'b00);
    chk("kmax_adr", PMPWrAdr, 54'h1F_FFFF_FFFF_FFFF);
    chk("kmax_cfg", PMPWrCfg, 8'h1F);

    // Size / alignment errors
    run(4'd3, 56'h8000_0800, 6'd12, 3'b011, 1'b0, lat, err, nwr);
    chk("misalign_lat", lat, 2);
    chk("misalign_err", err, 2'b01);
    chk("misalign_nwr", nwr, 0);
    run(4'd3, 56'h8000_0000, 6'd1, 3'b011, 1'b0, lat, err, nwr);
    chk("k1_err", err, 2'b01);
    chk("k1_nwr", nwr, 0);
    run(4'd3, 56'h0, 6'd57, 3'b011, 1'b0, lat, err, nwr);
    chk("k57_err", err, 2'b01);
    chk("k57_nwr", nwr, 0);

    // Lock errors
    PMPLocked = 16'h0020;
    run(4'd5, 56'h8000_0000, 6'd12, 3'b011, 1'b0, lat, err, nwr);
    chk("lock_self_lat", lat, 2);
    chk("lock_self_err", err, 2'b10);
    chk("lock_self_nwr", nwr, 0);
    run(4'd5, 56'h8000_0004, 6'd12, 3'b011, 1'b0, lat, err, nwr);
    chk("lock_prio_err", err, 2'b01);
    PMPIsTOR = 16'h0020;
    run(4'd4, 56'h8000_0000, 6'd12, 3'b011, 1'b0, lat, err, nwr);
    chk("lock_tor_err", err, 2'b10);
    chk("lock_tor_nwr", nwr, 0);
    PMPLocked = 16'h0001;
    PMPIsTOR  = 16'h0001;
    run(4'd15, 56'h8000_0000, 6'd12, 3'b011, 1'b0, lat, err, nwr);
    chk("last_entry_err", err, 2'b00);
    chk("last_entry_nwr", nwr, 1);
    PMPLocked = '0;
    PMPIsTOR  = '0;

    // Readback mismatch from granularity clamp
    clamp_en = 1'b1;
    run(4'd2, 56'h8000_0000, 6'd12, 3'b011, 1'b0, lat, err, nwr);
    chk("clamp_lat", lat, 4);
    chk("clamp_err", err, 2'b11);
    chk("clamp_nwr", nwr, 1);
    clamp_en = 1'b0;

    // Reset in the middle of WRITE
    @(negedge clk);
    ReqValid = 1'b1; ReqEntry = 4'd6; ReqBase = 56'h8000_0000; ReqLog2Size = 6'd12;
    ReqPerm = 3'b011; ReqLock = 1'b0;
    @(negedge clk);
    ReqValid = 1'b0;
    @(negedge clk);
    chk("mid_wren_before", PMPWrEn, 1'b1);
    nwr = wr_count;
    reset = 1'b1;
    #1;
    chk("mid_wren_async", PMPWrEn, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("mid_nwr", wr_count - nwr, 0);
    #1;
    chk("mid_ready", ReqReady, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("mid_no_rsp", RspValid, 1'b0);
    end

    run(4'd3, 56'h8000_0000, 6'd12, 3'b011, 1'b0, lat, err, nwr);
    chk("post_lat", lat, 4);
    chk("post_err", err, 2'b00);
    chk("post_adr", PMPWrAdr, 54'h2000_01FF);
    chk("post_cfg", PMPWrCfg, 8'h1B);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
